fetch_prefetch_unit: RTL and testbench

FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

---
 rtl/fetch_prefetch_unit_if.sv | 26 ++
 rtl/fetch_prefetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory and consumer-side bus of the fetch/prefetch unit.
// master = the fetch unit, slave = memory plus instruction consumer.
interface fetch_prefetch_unit_if #(
  parameter int BUS = 32
);
  logic           imem_req;
  logic [BUS-1:0] imem_addr;
  logic           imem_ack;
  logic [BUS-1:0] imem_data;
  logic           instr_valid;
  logic [BUS-1:0] instr;
  logic [BUS-1:0] instr_pc;
  logic           instr_ready;
  logic           redirect;
  logic [BUS-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_data, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_data, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue and redirect handling.
// Define FETCH_BYPASS_EN to present an acked word directly when the queue is empty.
module fetch_prefetch_unit #(
  parameter int BUS   = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_prefetch_unit_if.master  bus,
  output logic [1:0]             o_dbg_state,
  output logic [$clog2(DEPTH):0] o_dbg_count
);
  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [BUS-1:0] r_pc;
  logic [BUS-1:0] r_req_addr;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic [BUS-1:0] r_fifo_pc    [DEPTH];
  logic [BUS-1:0] r_fifo_instr [DEPTH];

  logic           w_empty;
  logic           w_issue;
  logic           w_ack_ok;
  logic           w_bypass;
  logic           w_push;
  logic           w_pop;
  logic [BUS-1:0] w_redir_pc;
  logic           w_unused;

  assign w_unused   = ^bus.redirect_pc[1:0];
  assign w_redir_pc = {bus.redirect_pc[BUS-1:2], 2'b00};

  // Handshakes: imem_req/imem_addr are held from issue until the cycle with
  // imem_ack=1, which completes the read; an instruction word transfers on a
  // rising edge where instr_valid && instr_ready, and valid never waits on ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // An issue acked in the same cycle completes without leaving IDLE.
        if (w_issue && !bus.imem_ack)
          w_state_nxt = bus.redirect ? ST_DISCARD : ST_REQ;
      end
      ST_REQ: begin
        if (bus.imem_ack)     w_state_nxt = ST_IDLE;
        else if (bus.redirect) w_state_nxt = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (bus.imem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_empty  = (r_count == '0);
    // The ack writes the FIFO at the same edge, so no word is ever in flight
    // outside the counter and the occupancy alone gates a new issue.
    w_issue  = reset && (r_state == ST_IDLE) && (r_count < DEPTH_C);
    w_ack_ok = bus.imem_ack && ((r_state == ST_REQ) || w_issue) && !bus.redirect;
`ifdef FETCH_BYPASS_EN
    w_bypass = w_empty && w_ack_ok;
`else
    w_bypass = 1'b0;
`endif
    w_pop    = !w_empty && bus.instr_ready && !bus.redirect;
    w_push   = w_ack_ok && !(w_bypass && bus.instr_ready);

    bus.imem_req    = (r_state != ST_IDLE) || w_issue;
    bus.imem_addr   = (r_state == ST_IDLE) ? r_pc : r_req_addr;
    bus.instr_valid = !w_empty || w_bypass;
    bus.instr       = '0;
    bus.instr_pc    = '0;
    if (!w_empty) begin
      bus.instr    = r_fifo_instr[r_rptr];
      bus.instr_pc = r_fifo_pc[r_rptr];
    end else if (w_bypass) begin
      bus.instr    = bus.imem_data;
      bus.instr_pc = bus.imem_addr;
    end

    o_dbg_state = r_state;
    o_dbg_count = r_count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= '0;
      r_req_addr <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) r_req_addr <= r_pc;
      if (bus.redirect) begin
        r_pc    <= w_redir_pc;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_ack_ok) r_pc   <= r_pc + BUS'(4);
        if (w_push)   r_wptr <= r_wptr + AW'(1);
        if (w_pop)    r_rptr <= r_rptr + AW'(1);
        r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
    end
  end

  // Storage needs no reset: the head is only presented while count != 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]    <= bus.imem_addr;
      r_fifo_instr[r_wptr] <= bus.imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed self-checking bench for fetch_prefetch_unit (BUS=32, DEPTH=4);
// expectations follow FETCH_BYPASS_EN where the bypass path changes timing.
module tb_fetch_prefetch_unit;
  localparam int BUS   = 32;
  localparam int DEPTH = 4;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        use_fixed  = 1'b0;
  logic [31:0] fixed_data = 32'h0;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  fetch_prefetch_unit_if #(.BUS(BUS)) bus ();

  fetch_prefetch_unit #(.BUS(BUS), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus.imem_data = use_fixed ? fixed_data : mem_word(bus.imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.imem_ack    = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // Reset held with ack active: everything quiet.
    step(); step(); #1;
    check("rst_req",   32'(bus.imem_req),    32'd0);
    check("rst_addr",  bus.imem_addr,        32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr,            32'd0);
    check("rst_pc",    bus.instr_pc,         32'd0);
    check("rst_state", 32'(dbg_state),       32'd0);
    check("rst_count", 32'(dbg_count),       32'd0);

    // Fill with ack tied high, consumer stalled.
    reset = 1'b1; #1;
    check("fill_req0",  32'(bus.imem_req), 32'd1);
    check("fill_addr0", bus.imem_addr,     32'd0);
    for (int i = 1; i < 4; i++) begin
      step(); #1;
      check("fill_addr",  bus.imem_addr,   32'(i * 4));
      check("fill_count", 32'(dbg_count),  32'(i));
    end
    step(); #1;
    check("full_req",   32'(bus.imem_req),    32'd0);
    check("full_count", 32'(dbg_count),       32'd4);
    check("full_valid", 32'(bus.instr_valid), 32'd1);
    check("full_pc",    bus.instr_pc,         32'd0);
    check("full_instr", bus.instr,            mem_word(32'd0));
    step(); #1;
    check("hold_req",   32'(bus.imem_req), 32'd0);
    check("hold_count", 32'(dbg_count),    32'd4);

    // Single pop from full queue, refill at 0x10.
    bus.instr_ready = 1'b1; #1;
    check("pop_pc",  bus.instr_pc,         32'd0);
    check("pop_req", 32'(bus.imem_req),    32'd0);
    step(); bus.instr_ready = 1'b0; #1;
    check("refill_count", 32'(dbg_count),    32'd3);
    check("refill_req",   32'(bus.imem_req), 32'd1);
    check("refill_addr",  bus.imem_addr,     32'h10);
    step(); #1;
    check("refull_count", 32'(dbg_count), 32'd4);
    check("refull_head",  bus.instr_pc,   32'h4);

    // Drain through the pointer wrap against the expected queue.
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i * 4));
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_pc = exp_q.pop_front();
      check("drain_valid", 32'(bus.instr_valid), 32'd1);
      check("drain_pc",    bus.instr_pc,         exp_pc);
      check("drain_instr", bus.instr,            mem_word(exp_pc));
      step();
    end
    bus.instr_ready = 1'b0; #1;
    check("drained_valid", 32'(bus.instr_valid), 32'd0);
    check("drained_state", 32'(dbg_state),       32'd1);
    check("drained_addr",  bus.imem_addr,        32'h14);

    // Reset in the middle of an outstanding request.
    reset = 1'b0; #1;
    check("midrst_req",   32'(bus.imem_req), 32'd0);
    check("midrst_state", 32'(dbg_state),    32'd0);
    check("midrst_addr",  bus.imem_addr,     32'd0);
    step();
    reset = 1'b1; #1;
    check("rerel_req",  32'(bus.imem_req), 32'd1);
    check("rerel_addr", bus.imem_addr,     32'd0);

    // Redirect to 0x103 while the read at 0x8 is outstanding.
    bus.imem_ack = 1'b1;
    step(); step();
    bus.imem_ack = 1'b0; #1;
    check("r8_addr",  bus.imem_addr,   32'h8);
    check("r8_count", 32'(dbg_count),  32'd2);
    step(); #1;
    check("r8_state", 32'(dbg_state),  32'd1);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h103; #1;
    step(); bus.redirect = 1'b0; #1;
    check("disc_state", 32'(dbg_state),       32'd2);
    check("disc_req",   32'(bus.imem_req),    32'd1);
    check("disc_addr",  bus.imem_addr,        32'h8);
    check("disc_valid", 32'(bus.instr_valid), 32'd0);
    step(); bus.imem_ack = 1'b1; #1;
    check("disc_ack_valid", 32'(bus.instr_valid), 32'd0);
    step(); bus.imem_ack = 1'b0; #1;
    check("post_disc_state", 32'(dbg_state),       32'd0);
    check("post_disc_addr",  bus.imem_addr,        32'h100);
    check("post_disc_valid", 32'(bus.instr_valid), 32'd0);
    check("post_disc_count", 32'(dbg_count),       32'd0);
    step(); bus.imem_ack = 1'b1; #1;
`ifdef FETCH_BYPASS_EN
    check("x100_ack_valid", 32'(bus.instr_valid), 32'd1);
    check("x100_ack_pc",    bus.instr_pc,         32'h100);
`else
    check("x100_ack_valid", 32'(bus.instr_valid), 32'd0);
`endif
    step(); bus.imem_ack = 1'b0; #1;
    check("x100_valid", 32'(bus.instr_valid), 32'd1);
    check("x100_pc",    bus.instr_pc,         32'h100);
    check("x100_instr", bus.instr,            mem_word(32'h100));
    check("x100_count", 32'(dbg_count),       32'd1);
    check("x100_next",  bus.imem_addr,        32'h104);

    // Redirect coinciding with ack.
    step(); #1;
    check("x104_state", 32'(dbg_state), 32'd1);
    bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h200; #1;
    step(); bus.imem_ack = 1'b0; bus.redirect = 1'b0; #1;
    check("coinc_count", 32'(dbg_count),       32'd0);
    check("coinc_valid", 32'(bus.instr_valid), 32'd0);
    check("coinc_state", 32'(dbg_state),       32'd0);
    check("coinc_addr",  bus.imem_addr,        32'h200);

    // PC wrap from 0xFFFFFFFC; low redirect bits ignored.
    bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE; #1;
    step(); bus.redirect = 1'b0; #1;
    check("top_addr",  bus.imem_addr,   32'hFFFF_FFFC);
    check("top_count", 32'(dbg_count),  32'd0);
    step(); bus.imem_ack = 1'b0; #1;
    check("wrap_addr",  bus.imem_addr,  32'h0);
    check("wrap_count", 32'(dbg_count), 32'd1);
    check("wrap_pc",    bus.instr_pc,   32'hFFFF_FFFC);

    // Empty queue, consumer ready, fixed word 0xE3A00001 at 0x20.
    bus.redirect = 1'b1; bus.redirect_pc = 32'h20; #1;
    step(); bus.redirect = 1'b0; #1;
    check("b_disc_state", 32'(dbg_state),  32'd2);
    check("b_disc_addr",  bus.imem_addr,   32'h0);
    bus.imem_ack = 1'b1;
    step(); bus.imem_ack = 1'b0; #1;
    check("b_idle_addr",  bus.imem_addr,        32'h20);
    check("b_idle_valid", 32'(bus.instr_valid), 32'd0);
    use_fixed = 1'b1; fixed_data = 32'hE3A0_0001;
    bus.instr_ready = 1'b1; bus.imem_ack = 1'b1; #1;
`ifdef FETCH_BYPASS_EN
    check("b_ack_valid", 32'(bus.instr_valid), 32'd1);
    check("b_ack_instr", bus.instr,            32'hE3A0_0001);
    check("b_ack_pc",    bus.instr_pc,         32'h20);
    step(); bus.imem_ack = 1'b0; #1;
    check("b_next_valid", 32'(bus.instr_valid), 32'd0);
    check("b_next_count", 32'(dbg_count),       32'd0);
`else
    check("b_ack_valid", 32'(bus.instr_valid), 32'd0);
    step(); bus.imem_ack = 1'b0; #1;
    check("b_next_valid", 32'(bus.instr_valid), 32'd1);
    check("b_next_instr", bus.instr,            32'hE3A0_0001);
    check("b_next_pc",    bus.instr_pc,         32'h20);
    check("b_next_count", 32'(dbg_count),       32'd1);
`endif
    step(); bus.instr_ready = 1'b0; #1;
    check("b_end_count", 32'(dbg_count),       32'd0);
    check("b_end_valid", 32'(bus.instr_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
